// File: rtl/vc_arbiter.sv
// vc_arbiter: weighted round-robin arbiter moving words from two virtual-channel
// FIFOs (VC0, VC1) into two destination FIFOs (D0, D1). Bit 4 of each head
// word selects the destination. A VC may pop up to its weight in consecutive
// cycles before the other VC, if eligible, takes over. Pops are combinational
// from the registered state; the popped word and its push strobe appear one
// cycle later on registered outputs.
module vc_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       vc0_empty,
  input  logic       vc1_empty,
  input  logic [5:0] vc0_head,
  input  logic [5:0] vc1_head,
  input  logic       pause_d0,
  input  logic       pause_d1,
  input  logic [3:0] weight_vc0,
  input  logic [3:0] weight_vc1,
  output logic       pop_vc0,
  output logic       pop_vc1,
  output logic [5:0] data_out,
  output logic       push_d0,
  output logic       push_d1,
  output logic [1:0] grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_VC0  = 2'b01,
    ST_VC1  = 2'b10
  } state_t;

  state_t     state_r;
  logic [3:0] count_r;

  logic       elig0_s;
  logic       elig1_s;
  logic [3:0] eff_w_s;
  logic       burst_done_s;

  // A VC is eligible when it has data and its head's destination is not paused.
  always_comb begin
    elig0_s = 1'b0;
    elig1_s = 1'b0;
    if (!vc0_empty) begin
      elig0_s = vc0_head[4] ? !pause_d1 : !pause_d0;
    end else begin
      elig0_s = 1'b0;
    end
    if (!vc1_empty) begin
      elig1_s = vc1_head[4] ? !pause_d1 : !pause_d0;
    end else begin
      elig1_s = 1'b0;
    end
  end

  // Pop strobes: only the granted VC pops, and never while reset or disabled.
  always_comb begin
    pop_vc0 = 1'b0;
    pop_vc1 = 1'b0;
    if (!reset && enable) begin
      pop_vc0 = (state_r == ST_VC0) && elig0_s;
      pop_vc1 = (state_r == ST_VC1) && elig1_s;
    end else begin
      pop_vc0 = 1'b0;
      pop_vc1 = 1'b0;
    end
  end

  // Burst expiry: this pop is the last one allowed by the current VC's weight
  // (zero weight behaves as one; >= so a lowered weight expires on next pop).
  always_comb begin
    eff_w_s = 4'd1;
    case (state_r)
      ST_VC0:  eff_w_s = (weight_vc0 == 4'd0) ? 4'd1 : weight_vc0;
      ST_VC1:  eff_w_s = (weight_vc1 == 4'd0) ? 4'd1 : weight_vc1;
      default: eff_w_s = 4'd1;
    endcase
    burst_done_s = (({1'b0, count_r} + 5'd1) >= {1'b0, eff_w_s});
  end

  // Arbitration FSM, burst counter and registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      count_r  <= 4'd0;
      data_out <= 6'd0;
      push_d0  <= 1'b0;
      push_d1  <= 1'b0;
    end else begin
      if (pop_vc0) begin
        data_out <= vc0_head;
        push_d0  <= !vc0_head[4];
        push_d1  <= vc0_head[4];
      end else if (pop_vc1) begin
        data_out <= vc1_head;
        push_d0  <= !vc1_head[4];
        push_d1  <= vc1_head[4];
      end else begin
        push_d0  <= 1'b0;
        push_d1  <= 1'b0;
      end

      if (!enable) begin
        state_r <= ST_IDLE;
        count_r <= 4'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            count_r <= 4'd0;
            if (elig0_s) begin
              state_r <= ST_VC0;
            end else if (elig1_s) begin
              state_r <= ST_VC1;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_VC0: begin
            if (pop_vc0) begin
              if (burst_done_s) begin
                count_r <= 4'd0;
                state_r <= elig1_s ? ST_VC1 : ST_VC0;
              end else begin
                count_r <= count_r + 4'd1;
              end
            end else begin
              count_r <= 4'd0;
              state_r <= elig1_s ? ST_VC1 : ST_IDLE;
            end
          end
          ST_VC1: begin
            if (pop_vc1) begin
              if (burst_done_s) begin
                count_r <= 4'd0;
                state_r <= elig0_s ? ST_VC0 : ST_VC1;
              end else begin
                count_r <= count_r + 4'd1;
              end
            end else begin
              count_r <= 4'd0;
              state_r <= elig0_s ? ST_VC0 : ST_IDLE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            count_r <= 4'd0;
          end
        endcase
      end
    end
  end

  assign grant = state_r;

endmodule

// File: tb/tb_vc_arbiter.sv
// Testbench for vc_arbiter: directed scenarios with literal pop patterns plus
// randomized traffic, all compared every cycle against a behavioural model of
// the grant owner, the run length within the current grant and the output stage.
module tb_vc_arbiter;

  logic       clk = 1'b0;
  logic       reset, enable, vc0_empty, vc1_empty, pause_d0, pause_d1;
  logic [5:0] vc0_head, vc1_head;
  logic [3:0] weight_vc0, weight_vc1;
  logic       pop_vc0, pop_vc1, push_d0, push_d1;
  logic [5:0] data_out;
  logic [1:0] grant;

  // staged stimulus, applied at the falling edge by step()
  logic       s_reset, s_en, s_e0, s_e1, s_p0, s_p1;
  logic [5:0] s_h0, s_h1;
  logic [3:0] s_w0, s_w1;

  // behavioural model: who owns the grant (0 none, 1 VC0, 2 VC1), how many
  // words it has moved in this grant, and what the output stage holds
  int         m_owner, m_run, m_pd0, m_pd1;
  logic [5:0] m_data;

  int total = 0;
  int bad   = 0;
  int obs_pop;

  vc_arbiter dut (
    .clk(clk), .reset(reset), .enable(enable),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_head(vc0_head), .vc1_head(vc1_head),
    .pause_d0(pause_d0), .pause_d1(pause_d1),
    .weight_vc0(weight_vc0), .weight_vc1(weight_vc1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .data_out(data_out), .push_d0(push_d0), .push_d1(push_d1),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int ready(input logic e, input logic [5:0] h,
                               input logic p0, input logic p1);
    return (!e && !(h[4] ? p1 : p0)) ? 1 : 0;
  endfunction

  // One clock cycle: apply staged inputs, compare every output against the
  // model, then advance the model to what the next rising edge must produce.
  task automatic step();
    int el0, el1, ex0, ex1, mine, other, lim;
    @(negedge clk);
    reset = s_reset; enable = s_en; vc0_empty = s_e0; vc1_empty = s_e1;
    vc0_head = s_h0; vc1_head = s_h1; pause_d0 = s_p0; pause_d1 = s_p1;
    weight_vc0 = s_w0; weight_vc1 = s_w1;
    #1;
    el0 = ready(s_e0, s_h0, s_p0, s_p1);
    el1 = ready(s_e1, s_h1, s_p0, s_p1);
    ex0 = (!s_reset && s_en && m_owner == 1 && el0 == 1) ? 1 : 0;
    ex1 = (!s_reset && s_en && m_owner == 2 && el1 == 1) ? 1 : 0;
    obs_pop = {30'd0, pop_vc1, pop_vc0};
    chk("pop_vc0", int'(pop_vc0), ex0);
    chk("pop_vc1", int'(pop_vc1), ex1);
    chk("grant", int'(grant), m_owner);
    chk("push_d0", int'(push_d0), m_pd0);
    chk("push_d1", int'(push_d1), m_pd1);
    chk("data_out", int'(data_out), int'(m_data));

    if (s_reset) begin
      m_owner = 0; m_run = 0; m_data = 6'd0; m_pd0 = 0; m_pd1 = 0;
    end else begin
      if (ex0 == 1) begin
        m_data = s_h0; m_pd0 = s_h0[4] ? 0 : 1; m_pd1 = s_h0[4] ? 1 : 0;
      end else if (ex1 == 1) begin
        m_data = s_h1; m_pd0 = s_h1[4] ? 0 : 1; m_pd1 = s_h1[4] ? 1 : 0;
      end else begin
        m_pd0 = 0; m_pd1 = 0;
      end
      if (!s_en) begin
        m_owner = 0; m_run = 0;
      end else if (m_owner == 0) begin
        m_owner = (el0 == 1) ? 1 : ((el1 == 1) ? 2 : 0);
        m_run = 0;
      end else begin
        mine  = (m_owner == 1) ? el0 : el1;
        other = (m_owner == 1) ? el1 : el0;
        lim   = (m_owner == 1) ? int'(s_w0) : int'(s_w1);
        if (lim == 0) lim = 1;
        if (mine == 1) begin
          if (m_run + 1 >= lim) begin
            m_run = 0;
            if (other == 1) m_owner = 3 - m_owner;
          end else begin
            m_run = m_run + 1;
          end
        end else begin
          m_run = 0;
          m_owner = (other == 1) ? 3 - m_owner : 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    s_reset = 1'b1; step();
    s_reset = 1'b0;
  endtask

  initial begin
    s_reset = 1'b1; s_en = 1'b1; s_e0 = 1'b1; s_e1 = 1'b1;
    s_h0 = 6'd0; s_h1 = 6'd0; s_p0 = 1'b0; s_p1 = 1'b0;
    s_w0 = 4'd1; s_w1 = 4'd1;
    m_owner = 0; m_run = 0; m_data = 6'd0; m_pd0 = 0; m_pd1 = 0;
    step(); step();
    s_reset = 1'b0;
    step();
    chk("rst_grant", int'(grant), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_push", int'({push_d1, push_d0}), 0);

    // VC0 holds three D0 words, VC1 empty
    begin : t_three
      int words;
      int pp[6] = '{0, 1, 1, 1, 0, 0};
      int pu[6] = '{0, 0, 1, 1, 1, 0};
      int gr[6] = '{0, 1, 1, 1, 1, 0};
      words = 3;
      s_w0 = 4'd2; s_w1 = 4'd2; s_e1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
        s_e0 = (words == 0);
        s_h0 = 6'h20 | 6'(words);
        step();
        chk("three_pop", obs_pop, pp[i]);
        chk("three_push_d0", int'(push_d0), pu[i]);
        chk("three_grant", int'(grant), gr[i]);
        if (obs_pop[0] && words > 0) words--;
      end
      chk("three_last_data", int'(data_out), 'h21);
    end

    // weights 2/1, both eligible to D0
    begin : t_weighted
      int pp[7] = '{0, 1, 1, 2, 1, 1, 2};
      do_reset();
      s_e0 = 1'b0; s_e1 = 1'b0; s_h0 = 6'h01; s_h1 = 6'h02;
      s_w0 = 4'd2; s_w1 = 4'd1;
      for (int i = 0; i < 7; i++) begin
        step();
        chk("weighted_pop", obs_pop, pp[i]);
      end
    end

    // zero weight acts as one: strict alternation
    begin : t_zero
      int pp[6] = '{0, 1, 2, 1, 2, 1};
      do_reset();
      s_w0 = 4'd0; s_w1 = 4'd1;
      for (int i = 0; i < 6; i++) begin
        step();
        chk("zero_w_pop", obs_pop, pp[i]);
      end
    end

    // VC0 blocked by pause on D1, released while VC1 is mid-burst
    begin : t_pause
      int pp[4] = '{0, 2, 2, 1};
      do_reset();
      s_h0 = 6'h11; s_h1 = 6'h02; s_p1 = 1'b1; s_w0 = 4'd2; s_w1 = 4'd2;
      for (int i = 0; i < 4; i++) begin
        if (i == 2) s_p1 = 1'b0;
        step();
        chk("pause_pop", obs_pop, pp[i]);
      end
    end

    // reset in the middle of a weight-4 VC1 burst, then a full-weight restart
    begin : t_midreset
      int pp[10] = '{0, 2, 2, 0, 0, 2, 2, 2, 2, 1};
      do_reset();
      s_e0 = 1'b1; s_e1 = 1'b0; s_h1 = 6'h13; s_w0 = 4'd1; s_w1 = 4'd4;
      for (int i = 0; i < 10; i++) begin
        s_reset = (i == 3);
        if (i == 5) s_e0 = 1'b0;
        step();
        chk("midreset_pop", obs_pop, pp[i]);
        if (i == 4) begin
          chk("midreset_grant", int'(grant), 0);
          chk("midreset_push", int'({push_d1, push_d0}), 0);
        end
      end
      s_reset = 1'b0;
    end

    // enable dropped for three cycles mid-burst
    begin : t_enable
      int pp[8] = '{0, 1, 1, 0, 0, 0, 0, 1};
      do_reset();
      s_e0 = 1'b0; s_e1 = 1'b0; s_h0 = 6'h04; s_h1 = 6'h08;
      s_w0 = 4'd3; s_w1 = 4'd3;
      for (int i = 0; i < 8; i++) begin
        s_en = !(i >= 3 && i <= 5);
        step();
        chk("enable_pop", obs_pop, pp[i]);
        if (i == 5) chk("enable_grant", int'(grant), 0);
      end
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s_reset = ($urandom_range(0, 63) == 0);
      s_en    = ($urandom_range(0, 15) != 0);
      s_e0    = ($urandom_range(0, 3) == 0);
      s_e1    = ($urandom_range(0, 3) == 0);
      s_h0    = 6'($urandom);
      s_h1    = 6'($urandom);
      s_p0    = ($urandom_range(0, 4) == 0);
      s_p1    = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 31) == 0) s_w0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) s_w1 = 4'($urandom_range(0, 15));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-003 enable  input  1  arbitration enable; 0 = no pops, return to IDLE.
REQ-004 vc0_empty  input  1  VC0 FIFO empty flag.
REQ-005 vc1_empty  input  1  VC1 FIFO empty flag.
REQ-006 vc0_head  input  6  VC0 FIFO head word (read-ahead); bit 4 = destination (0 = D0, 1 = D1).
REQ-007 vc1_head  input  6  VC1 FIFO head word, same encoding.
REQ-008 pause_d0  input  1  D0 FIFO almost-full pause.
REQ-009 pause_d1  input  1  D1 FIFO almost-full pause.
REQ-010 weight_vc0  input  4  max consecutive VC0 pops per grant; 0 treated as 1.
REQ-011 weight_vc1  input  4  same for VC1.
REQ-012 pop_vc0  output  1  combinational pop strobe to VC0 FIFO.
REQ-013 pop_vc1  output  1  combinational pop strobe to VC1 FIFO.
REQ-014 data_out  output  6  registered word popped in previous cycle.
REQ-015 push_d0  output  1  registered push to D0 FIFO.
REQ-016 push_d1  output  1  registered push to D1 FIFO.
REQ-017 grant  output  2  current state: 00 IDLE, 01 VC0, 10 VC1.

Function
REQ-018 eligN = !vcN_empty AND !(vcN_head[4] ? pause_d1 : pause_d0), evaluated on current inputs.
REQ-019 States IDLE, VC0, VC1; encoding 11 unreachable and SHALL map to IDLE next cycle.
REQ-020 pop_vcN = enable AND (state == VCN) AND eligN; never both high; never high in IDLE.
REQ-021 IDLE: elig0 -> VC0; else elig1 -> VC1; else stay; VC0 wins when both eligible.
REQ-022 VCn with popN and burst count+1 == effective weight: go to other VC if it is eligible, else remain in VCn with count cleared.
REQ-023 VCn with !eligN: go to other VC if eligible, else IDLE.
REQ-024 4-bit burst counter increments on each pop, clears on every state change, on weight expiry and in IDLE; never wraps (max weight 15).
REQ-025 enable = 0: pops forced 0, next state IDLE, counter cleared; registered outputs still drain the previous cycle's pop.
REQ-026 Latency 1: cycle after pop_vcN, data_out = vcN_head sampled at pop, push_d0 = !head[4], push_d1 = head[4]; otherwise push_d0/push_d1 = 0 and data_out holds last value.
REQ-027 Pause asserting in same cycle as a would-be pop blocks that pop (REQ-018 uses current pause).
REQ-028 Weight change mid-burst takes effect on the next compare; if count already >= new weight, expiry applies on the next pop.

Reset
REQ-029 reset = 1: state IDLE, grant 00, counter 0, data_out 000000, push_d0 = push_d1 = 0, pops 0 regardless of other inputs.
REQ-030 Reset mid-burst abandons the grant; no push occurs in the cycle after reset is applied, even if a pop occurred in the reset cycle's preceding edge window.

Verification
REQ-031 Reset then VC0 holds 3 words (dest D0), VC1 empty, weights 2/2 -> IDLE one cycle, then pop_vc0 on 3 consecutive cycles, push_d0 1 cycle after each, grant stays 01.
REQ-032 Both VCs non-empty, dest D0, weights 2/1 -> pop pattern VC0,VC0,VC1,VC0,VC0,VC1; one bubble only at start from IDLE.
REQ-033 VC0 head dest D1 with pause_d1 = 1, VC1 head dest D0 -> VC1 served; release pause_d1 -> VC0 granted after VC1 weight expiry.
REQ-034 weight_vc0 = 0, both eligible -> strict alternation VC0,VC1 when weight_vc1 = 1.
REQ-035 Assert reset during VC1 burst after 2 pops (weight 4) -> next cycle grant 00, push_d0/push_d1 = 0, counter 0; restart gives full weight.
REQ-036 Drop enable for 3 cycles mid-burst -> no pops, grant 00; re-enable with both eligible -> VC0 granted.
